delay_line_ctrl: RTL and testbench
==================================

# delay_line_ctrl

Programmable-latency delay line controller. It sequences a chain of one-cycle delay stages and taps the chain at a runtime-selected depth, giving an exact D-cycle delay for a valid-qualified sample stream. Changing the delay is safe: the controller stalls input, drains in-flight samples at the old delay, then switches. It sits between a producer and any consumer that needs a fixed, software-selectable pipeline alignment.

## Interface
- WIDTH, 8: data width in bits.
- MAX_DELAY, 16: number of delay stages and the largest legal delay (≥2).
- RESET_DELAY, 1: delay in force after reset (1..MAX_DELAY).
- DW, $clog2(MAX_DELAY+1): derived width of delay and count fields.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input sample present.
- in_ready  out  1  controller accepts input; accept = in_valid & in_ready at a rising edge.
- in_data  in  WIDTH  input sample.
- out_valid  out  1  delayed sample present; one cycle per accepted sample; no backpressure.
- out_data  out  WIDTH  delayed sample; 0 when out_valid=0.
- cfg_load  in  1  request new delay from cfg_delay.
- cfg_delay  in  DW  requested delay in cycles.
- cfg_busy  out  1  reconfiguration in progress.
- cfg_done  out  1  one-cycle pulse: new delay now in force.
- cfg_err  out  1  one-cycle pulse: request rejected.
- cur_delay  out  DW  delay currently in force.

## Operation
- Datapath: MAX_DELAY stages of {valid, data}; stage 0 captures {accept, in_data} every edge; stage i captures stage i-1 every edge. Chain always advances; bubbles carry valid=0.
- Output: out_valid/out_data = stage[cur_delay-1] (data forced to 0 when its valid=0).
- In-flight counter (DW bits): +1 on accept, -1 on out_valid, unchanged when both. Never exceeds MAX_DELAY.
- States: RUN, DRAIN. Reset state RUN.
- RUN: in_ready=1. On cfg_load: cfg_delay in 1..MAX_DELAY → DRAIN, latch pending delay, cfg_busy=1 next cycle; otherwise stay RUN, pulse cfg_err next cycle, cur_delay unchanged.
- DRAIN: in_ready=0, cfg_busy=1; old delay still used for output. When in-flight counter = 0 (sampled at an edge): cur_delay ← pending, → RUN, cfg_done pulses the following cycle.
- cfg_load in DRAIN: ignored, no cfg_err.
- cfg_load with in_valid at same RUN edge: the sample is accepted and counted, and drains at the old delay.
- Same-value cfg_load: full RUN→DRAIN→RUN sequence, no shortcut.
- Reset mid-DRAIN: in-flight samples discarded, cur_delay=RESET_DELAY, state RUN.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, cfg_busy=0, cfg_done=0, cfg_err=0, cur_delay=RESET_DELAY, all stage valids 0, counter 0.
- Latency: sample accepted at edge k appears on out_valid/out_data after edge k+D-1; D=1 equals a plain register.
- Throughput: one sample per cycle in RUN.
- Reconfig: cfg_load at edge k with nothing in flight → DRAIN after k, RUN and new cur_delay after k+1, cfg_done high in the cycle after k+1. With samples in flight, DRAIN lasts until the last sample has emitted (≤ old D cycles + 1).
- cfg_err: high exactly one cycle, after the edge that sampled the bad request.

## Configuration
- DELAY_LINE_CTRL_ZERO_DELAY_EN defined: cfg_delay=0 is legal. At D=0, out_valid=in_valid&in_ready and out_data=in_data combinationally, and the counter stays 0.
- Undefined: cfg_delay=0 is rejected with cfg_err. Output is always registered.

## Test plan
- Reset: assert rst_n=0 mid-stream → all outputs at reset values immediately; after release cur_delay=1, in_ready=1.
- D=1 stream: in_data 0x11,0x22,0x33 on consecutive edges → out_data 0x11,0x22,0x33 one edge later each, out_valid high 3 cycles.
- D=5 with bubbles: samples 0xA0 at edge 10 and 0xA1 at edge 12 → out_valid after edges 14 and 16 only, data matching.
- Drain: D=4, 3 samples in flight, cfg_load cfg_delay=2 → in_ready=0 until the 3 samples emit at delay 4, then cfg_done pulse, cur_delay=2; the next sample emits after 2 cycles.
- Errors: cfg_delay=MAX_DELAY+1 → cfg_err one cycle, cur_delay unchanged, in_ready stays 1. cfg_load during DRAIN → no effect.
- Macro: with DELAY_LINE_CTRL_ZERO_DELAY_EN, cfg_delay=0 then in_data=0x5A → out_data=0x5A in the same cycle. Without it, cfg_delay=0 → cfg_err pulse.

Source files
------------

// File: rtl/delay_line_ctrl.sv
// Programmable-latency delay line: taps a one-cycle stage chain at cur_delay and drains before a delay change.
// Optional: define DELAY_LINE_CTRL_ZERO_DELAY_EN to make cfg_delay=0 legal (combinational pass-through).
module delay_line_ctrl #(
    parameter int WIDTH       = 8,
    parameter int MAX_DELAY   = 16,
    parameter int RESET_DELAY = 1,
    parameter int DW          = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             cfg_load,
    input  logic [DW-1:0]    cfg_delay,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [DW-1:0]    cur_delay
);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t               state;
    logic [MAX_DELAY-1:0] stage_v;
    logic [WIDTH-1:0]     stage_d [MAX_DELAY];
    logic [MAX_DELAY-1:0] live_mask;
    logic [DW-1:0]        in_flight;
    logic [DW-1:0]        pending;
    logic                 accept;
    logic                 cfg_ok;
    logic                 tap_v;
    logic [WIDTH-1:0]     tap_d;

    assign in_ready = (state == RUN);
    assign cfg_busy = (state == DRAIN);
    assign accept   = in_valid & in_ready;

`ifdef DELAY_LINE_CTRL_ZERO_DELAY_EN
    assign cfg_ok = (cfg_delay <= DW'(MAX_DELAY));
`else
    assign cfg_ok = (cfg_delay != '0) && (cfg_delay <= DW'(MAX_DELAY));
`endif

    // Valids are only carried up to the tap, so an already-emitted sample can
    // never reappear at a deeper tap after the delay is increased.
    always_comb begin
        for (int i = 0; i < MAX_DELAY; i++) begin
            live_mask[i] = (DW'(i) < cur_delay);
        end
    end

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        tap_v = 1'b0;
        tap_d = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (DW'(i + 1) == cur_delay) begin
                tap_v = stage_v[i];
                tap_d = stage_d[i];
            end
        end
    end

`ifdef DELAY_LINE_CTRL_ZERO_DELAY_EN
    assign out_valid = (cur_delay == '0) ? accept : tap_v;
    assign out_data  = (cur_delay == '0) ? (accept ? in_data : '0) : (tap_v ? tap_d : '0);
`else
    assign out_valid = tap_v;
    assign out_data  = tap_v ? tap_d : '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_v <= '0;
        end else begin
            stage_v <= {stage_v[MAX_DELAY-2:0], accept} & live_mask;
        end
    end

    // NOTE: the data chain has no reset; stage_v qualifies it, which keeps this a plain shift memory.
    always_ff @(posedge clk) begin
        stage_d[0] <= in_data;
        for (int i = 1; i < MAX_DELAY; i++) begin
            stage_d[i] <= stage_d[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= '0;
        end else begin
            case ({accept, out_valid})
                2'b10:   in_flight <= in_flight + DW'(1);
                2'b01:   in_flight <= in_flight - DW'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            cur_delay <= DW'(RESET_DELAY);
            pending   <= DW'(RESET_DELAY);
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            case (state)
                RUN: begin
                    if (cfg_load) begin
                        if (cfg_ok) begin
                            state   <= DRAIN;
                            pending <= cfg_delay;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Requests arriving while draining are dropped silently.
                    if (in_flight == '0) begin
                        cur_delay <= pending;
                        state     <= RUN;
                        cfg_done  <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Scoreboard bench for delay_line_ctrl: expected samples and their due cycle are queued at drive time
// and matched against out_valid/out_data; reconfiguration timing is checked against a small model.
module tb_delay_line_ctrl;
    localparam int WIDTH       = 8;
    localparam int MAX_DELAY   = 16;
    localparam int RESET_DELAY = 1;
    localparam int DW          = $clog2(MAX_DELAY + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             cfg_load;
    logic [DW-1:0]    cfg_delay;
    logic             cfg_busy;
    logic             cfg_done;
    logic             cfg_err;
    logic [DW-1:0]    cur_delay;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   cyc         = 0;
    int   model_delay = RESET_DELAY;
    int   last_due    = -100;
    int   n_cmp       = 0;
    int   n_err       = 0;

    delay_line_ctrl #(
        .WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY), .RESET_DELAY(RESET_DELAY)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .cfg_load(cfg_load), .cfg_delay(cfg_delay),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .cur_delay(cur_delay)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out", out_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_cycle", cyc, e.due);
                end
            end else begin
                check("idle_data", out_data, '0);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    check("missing_out", out_valid, 1'b1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Sample is accepted at the coming edge (cyc+1) and due after edge cyc+D.
    task automatic push_exp(input logic [WIDTH-1:0] d);
        exp_t e;
        e.data = d;
        e.due  = cyc + model_delay;
        last_due = e.due;
        sb.push_back(e);
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        push_exp(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic reconfig(input int d, input logic with_sample, input logic [WIDTH-1:0] sd);
        int  k;
        int  exp_done;
        bit  seen;
        cfg_load  = 1'b1;
        cfg_delay = DW'(d);
        if (with_sample) begin
            in_valid = 1'b1;
            in_data  = sd;
            push_exp(sd);
        end
        tick();
        cfg_load = 1'b0;
        in_valid = 1'b0;
        k = cyc;
        exp_done = (last_due + 2 > k + 1) ? last_due + 2 : k + 1;
        check("busy_after_load", cfg_busy, 1'b1);
        // An illegal request during the drain must be ignored without an error.
        cfg_load  = 1'b1;
        cfg_delay = DW'(MAX_DELAY + 1);
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (cfg_done) begin
                seen = 1'b1;
                break;
            end
            check("drain_in_ready", in_ready, 1'b0);
            check("drain_no_err", cfg_err, 1'b0);
            tick();
            cfg_load = 1'b0;
        end
        cfg_load = 1'b0;
        check("cfg_done_seen", seen, 1'b1);
        check("done_cycle", cyc, exp_done);
        check("new_delay", cur_delay, d);
        check("busy_cleared", cfg_busy, 1'b0);
        check("ready_after_cfg", in_ready, 1'b1);
        check("no_err_at_done", cfg_err, 1'b0);
        model_delay = d;
        tick();
        check("done_one_cycle", cfg_done, 1'b0);
        check("no_err_after_done", cfg_err, 1'b0);
    endtask

    task automatic bad_cfg(input int d);
        cfg_load  = 1'b1;
        cfg_delay = DW'(d);
        tick();
        cfg_load = 1'b0;
        check("err_pulse", cfg_err, 1'b1);
        check("err_delay_kept", cur_delay, model_delay);
        check("err_ready", in_ready, 1'b1);
        check("err_not_busy", cfg_busy, 1'b0);
        tick();
        check("err_one_cycle", cfg_err, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        cfg_load  = 1'b0;
        cfg_delay = '0;
        idle(2);
        check("rst_cur_delay", cur_delay, RESET_DELAY);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_busy", cfg_busy, 1'b0);
        check("rst_done", cfg_done, 1'b0);
        check("rst_err", cfg_err, 1'b0);
        rst_n = 1'b1;
        idle(2);

        // D=1 back-to-back stream
        send(8'h11);
        send(8'h22);
        send(8'h33);
        idle(3);

        // D=5 with a bubble between samples
        reconfig(5, 1'b0, '0);
        send(8'hA0);
        idle(1);
        send(8'hA1);
        idle(8);

        // Drain: three samples in flight at D=4, switch to 2
        reconfig(4, 1'b0, '0);
        send(8'h31);
        send(8'h32);
        reconfig(2, 1'b1, 8'h33);
        send(8'h44);
        idle(4);

        // Boundary delays and rejected requests
        bad_cfg(MAX_DELAY + 1);
`ifdef DELAY_LINE_CTRL_ZERO_DELAY_EN
        reconfig(0, 1'b0, '0);
        send(8'h5A);
        send(8'hC3);
        idle(2);
`else
        bad_cfg(0);
`endif
        reconfig(MAX_DELAY, 1'b0, '0);
        send(8'hF0);
        idle(MAX_DELAY + 2);
        reconfig(3, 1'b0, '0);
        reconfig(3, 1'b0, '0);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else send(8'($urandom_range(0, 255)));
        end
        idle(5);

        // Asynchronous reset in the middle of a drain
        send(8'h61);
        send(8'h62);
        cfg_load  = 1'b1;
        cfg_delay = DW'(6);
        tick();
        cfg_load = 1'b0;
        check("pre_reset_busy", cfg_busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_data", out_data, '0);
        check("mid_rst_busy", cfg_busy, 1'b0);
        check("mid_rst_ready", in_ready, 1'b1);
        check("mid_rst_delay", cur_delay, RESET_DELAY);
        sb.delete();
        model_delay = RESET_DELAY;
        last_due    = -100;
        tick();
        rst_n = 1'b1;
        idle(8);
        check("post_rst_delay", cur_delay, RESET_DELAY);
        send(8'h77);
        idle(3);
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
